// File: rtl/rr_req_arbiter_n_pkg.sv
// Shared encodings for the N-master round-robin request arbiter.
// Pure definitions, no logic.
// No flow control of its own.
package rr_req_arbiter_n_pkg;

    typedef enum logic [1:0] {
        RS_NO_REQ = 2'd0,
        RS_WAIT   = 2'd1,
        RS_W_ACK  = 2'd2,
        RS_W_DATA = 2'd3
    } req_stat_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_e;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

endpackage

// File: rtl/rr_req_arbiter_n_rr_pick.sv
// Rotating (or fixed) priority encoder: picks one requester index.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module rr_pick
    import rr_req_arbiter_n_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          mode,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        if (mode == 1'(MODE_FIXED)) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !found) begin
                    idx   = IW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            // Scan starts one past the last winner so it gets lowest priority.
            for (int k = 1; k <= N; k++) begin
                j = (int'(last) + k) % N;
                if (req[j] && !found) begin
                    idx   = IW'(j);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_req_arbiter_n.sv
// N-master arbiter for one slave: picks an eligible master, offers its payload, pulses perm.
// Latency: eligible -> to_valid +1 cycle, to_ready -> perm +1 cycle, 3 cycles minimum per grant.
// Backpressure: offer held stable (payload, gnt_id) while to_ready is low.
module rr_req_arbiter_n
    import rr_req_arbiter_n_pkg::*;
#(
    parameter int N_MST = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int SW    = 1,
    parameter int MODE  = 0,
    localparam int IW   = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW-1:0]       s_no,
    input  logic [2*N_MST-1:0]  req_stat,
    input  logic [SW*N_MST-1:0] sfor,
    input  logic [N_MST-1:0]    cmd,
    input  logic [AW*N_MST-1:0] addr,
    input  logic [DW*N_MST-1:0] wdata,
    output logic [N_MST-1:0]    perm,
    output logic                to_valid,
    input  logic                to_ready,
    output logic [IW-1:0]       gnt_id,
    output logic [AW-1:0]       addr_to,
    output logic                cmd_to,
    output logic [DW-1:0]       wdata_to
);

    arb_state_e        state;
    logic [IW-1:0]     last;
    logic [N_MST-1:0]  elig;
    logic              pick_any;
    logic [IW-1:0]     pick_idx;
    logic [AW-1:0]     sel_addr;
    logic              sel_cmd;
    logic [DW-1:0]     sel_wdata;

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            elig[i] = (req_stat[2*i +: 2] == RS_WAIT) && (sfor[SW*i +: SW] == s_no);
        end
    end

    rr_pick #(
        .N  (N_MST),
        .IW (IW)
    ) u_pick (
        .req  (elig),
        .last (last),
        .mode (1'(MODE)),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_cmd   = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = addr[AW*i +: AW];
                sel_cmd   = cmd[i];
                sel_wdata = wdata[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            perm     <= '0;
            to_valid <= 1'b0;
            gnt_id   <= '0;
            addr_to  <= '0;
            cmd_to   <= 1'b0;
            wdata_to <= '0;
            last     <= IW'(N_MST - 1);
        end else begin
            perm <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_id   <= pick_idx;
                        addr_to  <= sel_addr;
                        cmd_to   <= sel_cmd;
                        wdata_to <= sel_wdata;
                        to_valid <= 1'b1;
                        state    <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    // Offer is committed: inputs are not looked at until the slave takes it.
                    if (to_ready) begin
                        to_valid <= 1'b0;
                        perm     <= N_MST'(1) << gnt_id;
                        state    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    last  <= gnt_id;
                    state <= ST_IDLE;
                end
                default: begin
                    to_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_req_arbiter_n.sv
// Directed bench for rr_req_arbiter_n: one round-robin and one fixed-priority instance
// on shared request inputs, outputs compared against hand-computed values.
module tb_rr_req_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 1;
    localparam int IW = 2;

    localparam logic [1:0] NO_REQ = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] W_ACK  = 2'd2;

    logic               clk;
    logic               rst_n;
    logic [SW-1:0]      s_no;
    logic [2*N-1:0]     req_stat;
    logic [SW*N-1:0]    sfor;
    logic [N-1:0]       cmd;
    logic [AW*N-1:0]    addr;
    logic [DW*N-1:0]    wdata;
    logic               to_ready;

    logic [N-1:0]       perm,     f_perm;
    logic               to_valid, f_to_valid;
    logic [IW-1:0]      gnt_id,   f_gnt_id;
    logic [AW-1:0]      addr_to,  f_addr_to;
    logic               cmd_to,   f_cmd_to;
    logic [DW-1:0]      wdata_to, f_wdata_to;

    int n_cmp;
    int n_err;

    rr_req_arbiter_n #(.N_MST(N), .AW(AW), .DW(DW), .SW(SW), .MODE(0)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_no     (s_no),
        .req_stat (req_stat),
        .sfor     (sfor),
        .cmd      (cmd),
        .addr     (addr),
        .wdata    (wdata),
        .perm     (perm),
        .to_valid (to_valid),
        .to_ready (to_ready),
        .gnt_id   (gnt_id),
        .addr_to  (addr_to),
        .cmd_to   (cmd_to),
        .wdata_to (wdata_to)
    );

    rr_req_arbiter_n #(.N_MST(N), .AW(AW), .DW(DW), .SW(SW), .MODE(1)) u_fix (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_no     (s_no),
        .req_stat (req_stat),
        .sfor     (sfor),
        .cmd      (cmd),
        .addr     (addr),
        .wdata    (wdata),
        .perm     (f_perm),
        .to_valid (f_to_valid),
        .to_ready (to_ready),
        .gnt_id   (f_gnt_id),
        .addr_to  (f_addr_to),
        .cmd_to   (f_cmd_to),
        .wdata_to (f_wdata_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stat(input int m, input logic [1:0] v);
        req_stat[2*m +: 2] = v;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        s_no     = '0;
        req_stat = '0;
        sfor     = '0;
        cmd      = '0;
        to_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr[AW*i +: AW]  = 32'h1000 + 32'(i) * 32'h11;
            wdata[DW*i +: DW] = 32'hD000 + 32'(i);
        end

        // Reset state
        tick(); tick();
        check("rst_to_valid", 64'(to_valid), 64'd0);
        check("rst_perm",     64'(perm),     64'd0);
        check("rst_gnt_id",   64'(gnt_id),   64'd0);
        check("rst_addr_to",  64'(addr_to),  64'd0);
        rst_n = 1'b1;
        tick();

        // Single master m2, immediately accepted
        set_stat(2, WAIT);
        cmd[2]   = 1'b1;
        to_ready = 1'b1;
        tick();
        check("single_valid",  64'(to_valid), 64'd1);
        check("single_gnt",    64'(gnt_id),   64'd2);
        check("single_addr",   64'(addr_to),  64'h1022);
        check("single_cmd",    64'(cmd_to),   64'd1);
        check("single_wdata",  64'(wdata_to), 64'hD002);
        check("single_perm0",  64'(perm),     64'd0);
        tick();
        check("single_perm",   64'(perm),     64'b0100);
        check("single_vld_lo", 64'(to_valid), 64'd0);
        set_stat(2, W_ACK);
        tick();
        check("single_perm_end", 64'(perm), 64'd0);
        set_stat(2, NO_REQ);
        cmd[2] = 1'b0;
        tick();
        check("single_idle", 64'(to_valid), 64'd0);

        // Async reset during OFFER drops the request
        to_ready = 1'b0;
        set_stat(1, WAIT);
        tick();
        check("mid_valid", 64'(to_valid), 64'd1);
        check("mid_gnt",   64'(gnt_id),   64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(to_valid), 64'd0);
        check("arst_gnt",   64'(gnt_id),   64'd0);
        check("arst_addr",  64'(addr_to),  64'd0);
        check("arst_perm",  64'(perm),     64'd0);
        set_stat(1, NO_REQ);
        to_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_perm",  64'(perm),     64'd0);
        check("post_rst_valid", 64'(to_valid), 64'd0);

        // Fairness: all four continuously WAIT
        for (int i = 0; i < N; i++) set_stat(i, WAIT);
        for (int g = 0; g < 5; g++) begin
            tick();
            check($sformatf("rr_valid_%0d", g), 64'(to_valid), 64'd1);
            check($sformatf("rr_gnt_%0d", g),   64'(gnt_id),   64'(order[g]));
            check($sformatf("rr_addr_%0d", g),  64'(addr_to),  64'h1000 + 64'(order[g]) * 64'h11);
            tick();
            check($sformatf("rr_perm_%0d", g),  64'(perm),     64'(1) << order[g]);
            tick();
            check($sformatf("rr_perm_end_%0d", g), 64'(perm),  64'd0);
        end
        for (int i = 0; i < N; i++) set_stat(i, NO_REQ);
        tick();

        // Backpressure: offer committed while addr0 moves and m3 also requests
        to_ready = 1'b0;
        addr[0 +: AW] = 32'h100;
        set_stat(0, WAIT);
        tick();
        check("bp_valid", 64'(to_valid), 64'd1);
        check("bp_gnt",   64'(gnt_id),   64'd0);
        check("bp_addr",  64'(addr_to),  64'h100);
        set_stat(3, WAIT);
        for (int k = 0; k < 5; k++) begin
            addr[0 +: AW] = 32'h200 + 32'(k);
            tick();
            check($sformatf("bp_hold_addr_%0d", k),  64'(addr_to),  64'h100);
            check($sformatf("bp_hold_gnt_%0d", k),   64'(gnt_id),   64'd0);
            check($sformatf("bp_hold_perm_%0d", k),  64'(perm),     64'd0);
            check($sformatf("bp_hold_valid_%0d", k), 64'(to_valid), 64'd1);
        end
        to_ready = 1'b1;
        tick();
        check("bp_perm",  64'(perm),     64'b0001);
        check("bp_vld_lo", 64'(to_valid), 64'd0);
        set_stat(0, W_ACK);
        set_stat(3, NO_REQ);
        tick();
        check("bp_perm_end", 64'(perm), 64'd0);
        set_stat(0, NO_REQ);
        tick();

        // Slave filter: m1 targets another slave
        s_no = 1'b0;
        sfor[1] = 1'b1;
        set_stat(1, WAIT);
        tick();
        check("filt_valid_a", 64'(to_valid), 64'd0);
        tick();
        check("filt_valid_b", 64'(to_valid), 64'd0);
        sfor[1] = 1'b0;
        tick();
        check("filt_valid_c", 64'(to_valid), 64'd1);
        check("filt_gnt",     64'(gnt_id),   64'd1);
        tick();
        check("filt_perm",    64'(perm),     64'b0010);
        set_stat(1, NO_REQ);
        tick();
        check("filt_perm_end", 64'(perm), 64'd0);
        tick();

        // Fixed priority: m0 wins while it keeps WAIT, m3 only once m0 drops
        set_stat(0, WAIT);
        set_stat(3, WAIT);
        for (int g = 0; g < 3; g++) begin
            tick();
            check($sformatf("fix_gnt_%0d", g),  64'(f_gnt_id), 64'd0);
            tick();
            check($sformatf("fix_perm_%0d", g), 64'(f_perm),   64'b0001);
            if (g == 2) set_stat(0, W_ACK);
            tick();
        end
        set_stat(0, NO_REQ);
        tick();
        check("fix_gnt_m3",   64'(f_gnt_id),   64'd3);
        check("fix_valid_m3", 64'(f_to_valid), 64'd1);
        tick();
        check("fix_perm_m3",  64'(f_perm),     64'b1000);
        set_stat(3, NO_REQ);
        tick();
        check("fix_perm_end", 64'(f_perm), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
